// File: rtl/sme_host.sv
// Host-side transmitter for the string-matching engine: buffers string/pattern
// records from upstream, replays them with engine framing and reports the result.
module sme_host #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] in_type,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic [7:0] res_count,
    output logic       done,
    output logic       error
);
    localparam logic [1:0] T_STR = 2'b00;
    localparam logic [1:0] T_PAT = 2'b01;
    localparam logic [1:0] T_END = 2'b10;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_STR, LOAD_PAT, XMIT_STR, XMIT_PAT, GAP, WAIT_RES, REPORT, END, DONE
    } state_t;

    state_t state, state_d;

    logic [7:0] sbuf [32];
    logic [7:0] pbuf [8];

    logic [5:0]        slen, slen_d;
    logic [3:0]        plen, plen_d;
    logic [4:0]        idx, idx_d;
    logic [WCNT_W-1:0] wcnt, wcnt_d;
    logic              str_pend, str_pend_d;
    logic              str_seen, str_seen_d;
    logic              s_we, p_we;
    logic [4:0]        s_waddr;
    logic [2:0]        p_waddr;
    logic              clr_count;
    logic              accept;
    logic [7:0]        chardata_d;
    logic              isstring_d, ispattern_d;
    logic              res_valid_d, res_match_d, res_timeout_d;
    logic [4:0]        res_index_d;
    logic              done_d, error_d;

    // Gated by reset so every output reads 0 while reset is held.
    assign in_ready = reset && (state == IDLE || state == LOAD_STR || state == LOAD_PAT);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no path infers a latch.
        state_d       = state;
        slen_d        = slen;
        plen_d        = plen;
        idx_d         = idx;
        wcnt_d        = wcnt;
        str_pend_d    = str_pend;
        str_seen_d    = str_seen;
        s_we          = 1'b0;
        s_waddr       = slen[4:0];
        p_we          = 1'b0;
        p_waddr       = plen[2:0];
        clr_count     = 1'b0;
        chardata_d    = 8'h00;
        isstring_d    = 1'b0;
        ispattern_d   = 1'b0;
        res_valid_d   = 1'b0;
        res_match_d   = res_match;
        res_index_d   = res_index;
        res_timeout_d = res_timeout;
        done_d        = done;
        error_d       = error;

        case (state)
            IDLE: if (accept) begin
                case (in_type)
                    T_STR: begin
                        s_we       = 1'b1;
                        s_waddr    = 5'd0;
                        slen_d     = 6'd1;
                        str_seen_d = 1'b1;
                        if (in_last) begin
                            str_pend_d = 1'b1;
                            clr_count  = 1'b1;
                        end else begin
                            state_d = LOAD_STR;
                        end
                    end
                    T_PAT: begin
                        if (!str_seen) begin
                            error_d = 1'b1;
                        end else begin
                            p_we    = 1'b1;
                            p_waddr = 3'd0;
                            plen_d  = 4'd1;
                            idx_d   = 5'd0;
                            if (in_last) state_d = str_pend ? XMIT_STR : XMIT_PAT;
                            else         state_d = LOAD_PAT;
                        end
                    end
                    T_END:   state_d = END;
                    default: error_d = 1'b1;
                endcase
            end
            LOAD_STR: if (accept) begin
                if (in_type != T_STR) begin
                    error_d = 1'b1;
                end else begin
                    // An overflow byte is dropped, but its in_last still closes the record.
                    if (slen == 6'd32) begin
                        error_d = 1'b1;
                    end else begin
                        s_we   = 1'b1;
                        slen_d = slen + 6'd1;
                    end
                    if (in_last) begin
                        str_pend_d = 1'b1;
                        clr_count  = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            LOAD_PAT: if (accept) begin
                if (in_type != T_PAT) begin
                    error_d = 1'b1;
                end else begin
                    if (plen == 4'd8) begin
                        error_d = 1'b1;
                    end else begin
                        p_we   = 1'b1;
                        plen_d = plen + 4'd1;
                    end
                    if (in_last) begin
                        idx_d   = 5'd0;
                        state_d = str_pend ? XMIT_STR : XMIT_PAT;
                    end
                end
            end
            XMIT_STR: begin
                isstring_d = 1'b1;
                chardata_d = sbuf[idx];
                if ({1'b0, idx} == slen - 6'd1) begin
                    idx_d      = 5'd0;
                    str_pend_d = 1'b0;
                    state_d    = XMIT_PAT;
                end else begin
                    idx_d = idx + 5'd1;
                end
            end
            XMIT_PAT: begin
                ispattern_d = 1'b1;
                chardata_d  = pbuf[idx[2:0]];
                if (idx[2:0] == 3'(plen - 4'd1)) begin
                    idx_d   = 5'd0;
                    state_d = GAP;
                end else begin
                    idx_d = idx + 5'd1;
                end
            end
            GAP: begin
                wcnt_d  = '0;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (valid) begin
                    res_match_d   = match;
                    res_index_d   = match_index;
                    res_timeout_d = 1'b0;
                    state_d       = REPORT;
                end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                    res_match_d   = 1'b0;
                    res_index_d   = 5'd0;
                    res_timeout_d = 1'b1;
                    state_d       = REPORT;
                end else begin
                    wcnt_d = wcnt + WCNT_W'(1);
                end
            end
            REPORT: begin
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            END: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
        if (!reset) begin
            slen        <= 6'd0;
            plen        <= 4'd0;
            idx         <= 5'd0;
            wcnt        <= '0;
            str_pend    <= 1'b0;
            str_seen    <= 1'b0;
            chardata    <= 8'h00;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= 5'd0;
            res_timeout <= 1'b0;
            res_count   <= 8'd0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            slen        <= slen_d;
            plen        <= plen_d;
            idx         <= idx_d;
            wcnt        <= wcnt_d;
            str_pend    <= str_pend_d;
            str_seen    <= str_seen_d;
            chardata    <= chardata_d;
            isstring    <= isstring_d;
            ispattern   <= ispattern_d;
            res_valid   <= res_valid_d;
            res_match   <= res_match_d;
            res_index   <= res_index_d;
            res_timeout <= res_timeout_d;
            done        <= done_d;
            error       <= error_d;
            // The count steps after the result beat so the beat shows the current pattern number.
            if (clr_count)      res_count <= 8'd0;
            else if (res_valid) res_count <= res_count + 8'd1;
        end
    end

    // NOTE: the buffers are not reset; only entries below slen/plen are ever read and reset clears those.
    always_ff @(posedge clk) begin
        if (s_we) sbuf[s_waddr] <= in_data;
        if (p_we) pbuf[p_waddr] <= in_data;
    end

endmodule

// File: tb/tb_sme_host.sv
// Bench for sme_host: directed and random string/pattern jobs checked against a
// queue-based model of the engine-side bursts and the upstream result beats.
module tb_sme_host;
    localparam int TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_type = 2'b00;
    logic       in_last = 1'b0;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid = 1'b0;
    logic       match = 1'b0;
    logic [4:0] match_index = 5'd0;
    logic       res_valid, res_match, res_timeout, done, error;
    logic [4:0] res_index;
    logic [7:0] res_count;

    always #5 clk = ~clk;

    sme_host #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_type(in_type), .in_last(in_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .res_timeout(res_timeout), .res_count(res_count),
        .done(done), .error(error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [9:0] mon_q[$];
    int         mon_cyc[$];
    logic [9:0] exp_q[$];
    logic [7:0] str_q[$], pat_q[$], mdl_str[$];
    bit         mdl_pend = 1'b0;
    bit         exp_error = 1'b0;
    int         mdl_cnt = 0;
    logic [7:0] eng_s[32];
    logic [7:0] eng_p[8];
    int         eng_sl = 0;
    int         eng_pl = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine-side capture: one entry {isstring, ispattern, chardata} per strobed cycle.
    always @(negedge clk)
        if (isstring || ispattern) begin
            mon_q.push_back({isstring, ispattern, chardata});
            mon_cyc.push_back(cyc);
        end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int find_first(input logic [7:0] s[32], input int sl,
                                      input logic [7:0] p[8], input int pl);
        for (int i = 0; i + pl <= sl; i++) begin
            bit hit;
            hit = 1'b1;
            for (int j = 0; j < pl; j++) if (s[i+j] != p[j]) hit = 1'b0;
            if (hit) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [1:0] t, input logic l);
        int n;
        in_data = d; in_type = t; in_last = l; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) check("beat_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; valid = 1'b0;
        step();
        check("reset_outputs", 32'({in_ready, chardata, isstring, ispattern, res_valid, res_match,
                                    res_index, res_timeout, res_count, done, error}), 32'd0);
        step();
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);
        mdl_pend = 1'b0; exp_error = 1'b0; mdl_cnt = 0;
        mon_q.delete(); mon_cyc.delete();
    endtask

    task automatic send_string();
        foreach (str_q[i]) send_beat(str_q[i], 2'b00, 1'(i == str_q.size() - 1));
        mdl_str.delete();
        foreach (str_q[i]) if (i < 32) mdl_str.push_back(str_q[i]);
        if (str_q.size() > 32) exp_error = 1'b1;
        mdl_pend = 1'b1;
        mdl_cnt = 0;
    endtask

    // Sends pat_q, checks the engine burst, plays the engine, checks the result beat.
    task automatic run_pattern(input bit respond);
        int n, vcyc, gcyc, got, exp_idx, dt;
        logic [7:0] e_s[32];
        logic [7:0] e_p[8];
        mon_q.delete(); mon_cyc.delete();
        foreach (pat_q[i]) send_beat(pat_q[i], 2'b01, 1'(i == pat_q.size() - 1));
        exp_q.delete();
        if (mdl_pend) foreach (mdl_str[i]) exp_q.push_back({2'b10, mdl_str[i]});
        foreach (pat_q[i]) exp_q.push_back({2'b01, pat_q[i]});
        mdl_pend = 1'b0;
        n = 0;
        while (!(mon_q.size() >= exp_q.size() && !isstring && !ispattern) && n < 300) begin
            step(); n++;
        end
        gcyc = cyc;
        check("burst_len", 32'(mon_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) if (i < mon_q.size()) check("burst_byte", 32'(mon_q[i]), 32'(exp_q[i]));
        if (mon_q.size() > 0) begin
            check("first_byte_latency", 32'(mon_cyc[0]), 32'(acc_cyc + 1));
            check("burst_contiguous", 32'(mon_cyc[mon_q.size()-1]), 32'(mon_cyc[0] + mon_q.size() - 1));
            check("gap_cycle", 32'(gcyc), 32'(mon_cyc[mon_q.size()-1] + 1));
        end
        if (mon_q.size() > 0 && mon_q[0][9]) eng_sl = 0;
        eng_pl = 0;
        foreach (mon_q[i]) begin
            if (mon_q[i][9] && eng_sl < 32) begin eng_s[eng_sl] = mon_q[i][7:0]; eng_sl++; end
            if (mon_q[i][8] && eng_pl < 8) begin eng_p[eng_pl] = mon_q[i][7:0]; eng_pl++; end
        end
        got = find_first(eng_s, eng_sl, eng_p, eng_pl);
        foreach (mdl_str[i]) e_s[i] = mdl_str[i];
        foreach (pat_q[i]) e_p[i] = pat_q[i];
        exp_idx = find_first(e_s, mdl_str.size(), e_p, pat_q.size());
        vcyc = 0;
        if (respond) begin
            repeat ($urandom_range(0, 4)) step();
            valid = 1'b1;
            match = (got >= 0);
            match_index = (got >= 0) ? 5'(got) : 5'd0;
            vcyc = cyc;
            step();
            valid = 1'b0;
            match = 1'($urandom_range(0, 1));
            match_index = 5'($urandom);
        end
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin step(); n++; end
        check("res_valid_seen", 32'(res_valid), 32'd1);
        if (respond) begin
            check("res_latency", 32'(cyc), 32'(vcyc + 2));
        end else begin
            dt = cyc - (gcyc - 1);
            check("timeout_window", 32'(dt >= 11 && dt <= 12), 32'd1);
        end
        check("res_timeout", 32'(res_timeout), 32'(!respond));
        check("res_match", 32'(res_match), 32'(respond && exp_idx >= 0));
        check("res_index", 32'(res_index), 32'((respond && exp_idx >= 0) ? exp_idx : 0));
        check("res_count", 32'(res_count), 32'(mdl_cnt));
        step();
        check("res_valid_pulse", 32'(res_valid), 32'd0);
        mdl_cnt = (mdl_cnt + 1) % 256;
        check("res_count_next", 32'(res_count), 32'(mdl_cnt));
        check("error_flag", 32'(error), 32'(exp_error));
    endtask

    initial begin
        int n;
        do_reset();

        // Pattern before any string, then an illegal type.
        send_beat(8'h61, 2'b01, 1'b1);
        repeat (3) step();
        check("err_pat_first", 32'(error), 32'd1);
        check("no_strobe_pat_first", 32'(mon_q.size()), 32'd0);
        check("ready_pat_first", 32'(in_ready), 32'd1);
        do_reset();
        send_beat(8'h00, 2'b11, 1'b0);
        repeat (3) step();
        check("err_type11", 32'(error), 32'd1);
        check("no_strobe_type11", 32'(mon_q.size()), 32'd0);
        do_reset();

        str_q = '{8'h61, 8'h62, 8'h63};
        send_string();
        pat_q = '{8'h62, 8'h63};
        run_pattern(1'b1);
        pat_q = '{8'h78};
        run_pattern(1'b1);

        for (int it = 0; it < 10; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0) begin
                str_q.delete();
                repeat ($urandom_range(1, 32)) str_q.push_back(8'h61 + 8'($urandom_range(0, 3)));
                send_string();
            end
            pat_q.delete();
            repeat ($urandom_range(1, 8)) pat_q.push_back(8'h61 + 8'($urandom_range(0, 2)));
            run_pattern(1'b1);
        end

        pat_q = '{8'h61, 8'h62};
        run_pattern(1'b0);

        // 33-byte string: the last byte overflows, the engine sees 32.
        str_q.delete();
        for (int i = 0; i < 33; i++) str_q.push_back(8'($urandom_range(32, 126)));
        send_string();
        pat_q = '{8'h7a};
        run_pattern(1'b1);

        mon_q.delete(); mon_cyc.delete();
        send_beat(8'h00, 2'b10, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 10) begin step(); n++; end
        check("done_set", 32'(done), 32'd1);
        check("done_latency", 32'(cyc), 32'(acc_cyc + 1));
        check("eoj_no_strobes", 32'(mon_q.size()), 32'd0);
        check("ready_low_done", 32'(in_ready), 32'd0);
        repeat (5) step();
        check("done_sticky", 32'(done), 32'd1);
        check("ready_stays_low", 32'(in_ready), 32'd0);

        // Reset while the fifth string byte is on the engine bus.
        do_reset();
        str_q.delete();
        repeat (10) str_q.push_back(8'($urandom_range(32, 126)));
        send_string();
        mon_q.delete(); mon_cyc.delete();
        send_beat(8'h61, 2'b01, 1'b0);
        send_beat(8'h62, 2'b01, 1'b1);
        n = 0;
        while (mon_q.size() < 5 && n < 50) begin step(); n++; end
        check("mid_byte5", 32'(mon_q.size() >= 5 ? mon_q[4] : 10'd0), 32'({2'b10, str_q[4]}));
        do_reset();
        send_beat(8'h61, 2'b01, 1'b1);
        repeat (3) step();
        check("err_after_mid_reset", 32'(error), 32'd1);
        check("no_strobe_after_mid_reset", 32'(mon_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
